uart_tx_shifter: RTL and testbench

//  Serial transmitter stage fed by the baud tick generator. It accepts a parallel word

---
 rtl/uart_tx_shifter.sv | 142 ++++++++++++++
 tb/tb_uart_tx_shifter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_shifter.sv
// UART transmit shifter: accepts a word on valid/ready and sends start, data LSB-first,
// optional even parity (build with UART_TX_PARITY_EN), and STOP_BITS stop periods.
module uart_tx_shifter #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 CLKIN,
  input  logic                 RESETN,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int CW = $clog2(DATA_BITS) + 1;
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      // A tick coinciding with accept is deliberately ignored; SYNC aligns to the next one.
      S_IDLE: begin
        tx_d = 1'b1;
        if (valid) begin
          sr_d    = data;
`ifdef UART_TX_PARITY_EN
          par_d   = ^data;
`endif
          state_d = S_SYNC;
        end
      end
      S_SYNC: begin
        if (baud_tick) begin
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_tick) begin
          state_d = S_DATA;
          tx_d    = sr_q[0];
          sr_d    = sr_q >> 1;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (cnt_q != LAST_DATA) begin
            tx_d  = sr_q[0];
            sr_d  = sr_q >> 1;
            cnt_d = cnt_q + CW'(1);
          end else begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
            cnt_d   = '0;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_tick) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          cnt_d   = '0;
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (baud_tick) begin
          if (cnt_q != LAST_STOP) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = (state_q != S_IDLE);
  assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_shifter.sv
// Bench for uart_tx_shifter: two instances (8N1 and 5-bit/2-stop) checked every cycle
// against a frame-level model, plus literal frame sequences and reset/back-to-back cases.
module tb_uart_tx_shifter;
  localparam int DB0 = 8, SB0 = 1, DB1 = 5, SB1 = 2;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       CLKIN = 1'b0;
  logic       RESETN = 1'b1;
  logic [1:0] tck = '0;
  logic [1:0] vld = '0;
  logic [7:0] dat0 = '0;
  logic [4:0] dat1 = '0;
  logic [1:0] tx_o, rdy_o, bsy_o;

  int n_cmp = 0, n_err = 0;
  bit chk_en = 0, rnd = 0;
  int tper = 4, tdiv = 0;

  always #5 CLKIN = ~CLKIN;

  uart_tx_shifter #(.DATA_BITS(DB0), .STOP_BITS(SB0)) u_dut0 (
    .CLKIN(CLKIN), .RESETN(RESETN), .baud_tick(tck[0]), .data(dat0), .valid(vld[0]),
    .ready(rdy_o[0]), .tx(tx_o[0]), .busy(bsy_o[0]));

  uart_tx_shifter #(.DATA_BITS(DB1), .STOP_BITS(SB1)) u_dut1 (
    .CLKIN(CLKIN), .RESETN(RESETN), .baud_tick(tck[1]), .data(dat1), .valid(vld[1]),
    .ready(rdy_o[1]), .tx(tx_o[1]), .busy(bsy_o[1]));

  // Model: a frame is a list of line levels; tick k after accept shows level k-1,
  // tick flen+1 returns to idle.
  function automatic int dbits(int i);
    return (i == 0) ? DB0 : DB1;
  endfunction
  function automatic int flen(int i);
    return 1 + dbits(i) + PAR + ((i == 0) ? SB0 : SB1);
  endfunction
  function automatic logic [7:0] word(int i);
    return (i == 0) ? dat0 : {3'b000, dat1};
  endfunction
  function automatic logic [15:0] frame(int i);
    logic [15:0] f;
    logic [7:0]  w;
    logic        p;
    int          n;
    w = word(i); n = dbits(i); p = 1'b0;
    f = '1;
    f[0] = 1'b0;
    for (int j = 0; j < n; j++) begin
      f[j+1] = w[j];
      p = p ^ w[j];
    end
    if (PAR != 0) f[n+1] = p;
    return f;
  endfunction

  logic [1:0]  m_busy = '0;
  int          m_k [2];
  logic [15:0] m_fr [2];

  always @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] <= 1'b0;
        m_k[i]    <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_busy[i]) begin
          if (vld[i]) begin
            m_busy[i] <= 1'b1;
            m_k[i]    <= 0;
            m_fr[i]   <= frame(i);
          end
        end else if (tck[i]) begin
          m_k[i] <= m_k[i] + 1;
          if (m_k[i] == flen(i)) m_busy[i] <= 1'b0;
        end
      end
    end
  end

  function automatic logic exp_tx(int i);
    if (!m_busy[i] || m_k[i] == 0) return 1'b1;
    return m_fr[i][m_k[i]-1];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLKIN) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("tx%0d", i), {31'b0, tx_o[i]}, {31'b0, exp_tx(i)});
        chk($sformatf("ready%0d", i), {31'b0, rdy_o[i]}, {31'b0, ~m_busy[i]});
        chk($sformatf("busy%0d", i), {31'b0, bsy_o[i]}, {31'b0, m_busy[i]});
      end
    end
  end

  task automatic step();
    @(posedge CLKIN);
    #2;
    if (rnd) begin
      for (int i = 0; i < 2; i++) tck[i] = !tck[i] && ($urandom_range(0, 2) == 0);
    end else begin
      tdiv = (tdiv + 1) % tper;
      tck  = {2{tdiv == 0}};
    end
  endtask

  task automatic wait_tick(input int i);
    bit t;
    int n;
    n = 0;
    do begin
      t = tck[i];
      step();
      n++;
    end while (!t && n < 100);
    if (!t) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (bsy_o[i] && n < 400) begin
      step();
      n++;
    end
    chk("drain_busy", {31'b0, bsy_o[i]}, 32'd0);
  endtask

  // Accept d on instance i and compare tx after each tick with the literal seq (bit0 first).
  task automatic lit_frame(input int i, input logic [7:0] d, input logic [15:0] seq,
                           input int len, input bit tick_now);
    if (i == 0) dat0 = d; else dat1 = d[4:0];
    vld[i] = 1'b1;
    tck[i] = tick_now;
    tdiv   = 0;
    step();
    vld[i] = 1'b0;
    chk("acc_busy", {31'b0, bsy_o[i]}, 32'd1);
    chk("acc_tx", {31'b0, tx_o[i]}, 32'd1);
    for (int k = 1; k <= len; k++) begin
      wait_tick(i);
      chk($sformatf("lit_tx_%0d", k), {31'b0, tx_o[i]}, {31'b0, seq[k-1]});
      chk("lit_busy", {31'b0, bsy_o[i]}, 32'd1);
    end
    wait_tick(i);
    chk("lit_end_busy", {31'b0, bsy_o[i]}, 32'd0);
    chk("lit_end_ready", {31'b0, rdy_o[i]}, 32'd1);
    chk("lit_end_tx", {31'b0, tx_o[i]}, 32'd1);
  endtask

  initial begin
    int nr, n;
    bit seen;
    #1 RESETN = 1'b0;
    chk_en = 1;
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      chk("rst_tx", {31'b0, tx_o[i]}, 32'd1);
      chk("rst_ready", {31'b0, rdy_o[i]}, 32'd1);
      chk("rst_busy", {31'b0, bsy_o[i]}, 32'd0);
    end
    RESETN = 1'b1;
    repeat (3) step();

`ifdef UART_TX_PARITY_EN
    lit_frame(0, 8'h55, 16'h04AA, 11, 1'b0);
    repeat (2) step();
    lit_frame(0, 8'h55, 16'h04AA, 11, 1'b1);
    lit_frame(1, 8'h1F, 16'h01FE, 9, 1'b0);
    lit_frame(0, 8'h07, 16'h060E, 11, 1'b0);
    lit_frame(0, 8'h03, 16'h0406, 11, 1'b0);
`else
    lit_frame(0, 8'h55, 16'h02AA, 10, 1'b0);
    repeat (2) step();
    lit_frame(0, 8'h55, 16'h02AA, 10, 1'b1);
    lit_frame(1, 8'h1F, 16'h00FE, 8, 1'b0);
    lit_frame(0, 8'h07, 16'h020E, 10, 1'b0);
    lit_frame(0, 8'h03, 16'h0206, 10, 1'b0);
`endif

    // back-to-back with valid held high
    dat0 = 8'hA3; vld[0] = 1'b1;
    step();
    chk("b2b_acc", {31'b0, bsy_o[0]}, 32'd1);
    dat0 = 8'h0F;
    nr = 0; n = 0; seen = 0;
    while (n < 300 && !(seen && !rdy_o[0])) begin
      step();
      n++;
      if (rdy_o[0]) begin
        nr++;
        seen = 1;
      end
    end
    vld[0] = 1'b0;
    chk("b2b_ready_pulses", nr, 32'd1);
    wait_tick(0);
    chk("b2b_start", {31'b0, tx_o[0]}, 32'd0);
    wait_idle(0);

    // valid toggling with 0xFF while a 0x00 frame is in flight
    dat0 = 8'h00; vld[0] = 1'b1;
    step();
    for (int c = 0; c < 30; c++) begin
      dat0 = 8'hFF;
      vld[0] = ~vld[0];
      step();
      chk("t4_ready", {31'b0, rdy_o[0]}, 32'd0);
    end
    vld[0] = 1'b0;
    wait_idle(0);

    // reset during data bit 3
    dat0 = 8'h00; vld[0] = 1'b1;
    step();
    vld[0] = 1'b0;
    repeat (5) wait_tick(0);
    chk("t5_pre_tx", {31'b0, tx_o[0]}, 32'd0);
    step();
    RESETN = 1'b0;
    #1;
    chk("t5_rst_tx", {31'b0, tx_o[0]}, 32'd1);
    chk("t5_rst_ready", {31'b0, rdy_o[0]}, 32'd1);
    chk("t5_rst_busy", {31'b0, bsy_o[0]}, 32'd0);
    repeat (2) step();
    RESETN = 1'b1;
    repeat (40) step();
    chk("t5_quiet_busy", {31'b0, bsy_o[0]}, 32'd0);
    chk("t5_quiet_tx", {31'b0, tx_o[0]}, 32'd1);

    // randomized traffic and ticks
    rnd = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!vld[i] || $urandom_range(0, 3) == 0) vld[i] = ($urandom_range(0, 2) == 0);
      end
      dat0 = 8'($urandom);
      dat1 = 5'($urandom);
      if (c == 1500) RESETN = 1'b0;
      if (c == 1502) RESETN = 1'b1;
      step();
    end
    vld = '0;
    rnd = 0;
    wait_idle(0);
    wait_idle(1);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
